// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// Registered scan sequencer producing the 3-bit select {a,b,c} for a
// downstream decoder3to8. The index steps up, down, ping-pong or holds,
// dwelling (dwell+1) enabled cycles per index. Sweeps can free-run or be
// one-shot, and wrap pulses on each sweep completion.
//
// Optional feature: define SCAN_MASK_EN to add a live skip_mask[7:0] input.
// Masked indices are never visited.
//
// Handshake: there is no back-pressure. sel_valid (== busy) is high exactly
// while the block is in RUN. {a,b,c} is meaningful only while sel_valid is high.
// wrap is a one-cycle pulse aligned with the index update that completes a sweep.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               oneshot,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               wrap,
    output logic               busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_PP   = 2'b10;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_up_q, dir_up_d;
    logic [1:0]         mode_q, mode_d;
    logic               oneshot_q, oneshot_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               wrap_q, wrap_d;

    logic [7:0]         mask_w;
    logic               all_masked;

`ifdef SCAN_MASK_EN
    assign mask_w = skip_mask;
`else
    assign mask_w = 8'h00;
`endif

    assign all_masked = &mask_w;

    // Nearest unmasked index strictly beyond 'from' in one direction, with no
    // wrap-around. Returns {found, index}.
    function automatic logic [3:0] scan_next(input logic [2:0] from,
                                             input logic       up,
                                             input logic [7:0] m);
        logic [3:0] p;
        logic [3:0] r;
        r = 4'd0;
        for (int k = 7; k >= 1; k--) begin
            p = up ? ({1'b0, from} + 4'(k)) : ({1'b0, from} - 4'(k));
            if (!p[3] && !m[p[2:0]]) begin
                r = {1'b1, p[2:0]};
            end
        end
        return r;
    endfunction

    // First index of a new sweep: first unmasked index from the start point.
    logic [2:0] first_idx;
    logic [3:0] first_p;
    always_comb begin
        first_idx = 3'd0;
        first_p   = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            first_p = (mode == M_DOWN) ? 4'(7 - k) : 4'(k);
            if (!mask_w[first_p[2:0]]) begin
                first_idx = first_p[2:0];
            end
        end
    end

    // Index that follows idx_q in the running mode, with its direction and
    // whether this step completes a sweep.
    logic [2:0] adv_idx;
    logic       adv_dir_up;
    logic       adv_wrap;
    logic [3:0] adv_p;
    logic [3:0] pp_hit;
    logic [3:0] pp_beyond;
    logic       pp_eff_up;
    always_comb begin
        adv_idx    = idx_q;
        adv_dir_up = dir_up_q;
        adv_wrap   = 1'b0;
        adv_p      = 4'd0;
        pp_hit     = 4'd0;
        pp_beyond  = 4'd0;
        pp_eff_up  = dir_up_q;
        case (mode_q)
            M_UP: begin
                // Bit 3 of the sum marks a crossing of the 7->0 boundary.
                for (int k = 8; k >= 1; k--) begin
                    adv_p = {1'b0, idx_q} + 4'(k);
                    if (!mask_w[adv_p[2:0]]) begin
                        adv_idx  = adv_p[2:0];
                        adv_wrap = adv_p[3];
                    end
                end
            end
            M_DOWN: begin
                // Bit 3 of the difference marks a crossing of the 0->7 boundary.
                for (int k = 8; k >= 1; k--) begin
                    adv_p = {1'b0, idx_q} - 4'(k);
                    if (!mask_w[adv_p[2:0]]) begin
                        adv_idx  = adv_p[2:0];
                        adv_wrap = adv_p[3];
                    end
                end
            end
            M_PP: begin
                // Move ahead if possible, otherwise turn around. On arrival,
                // flip direction when nothing remains ahead; arriving at the
                // low turnaround completes a sweep.
                pp_hit = scan_next(idx_q, dir_up_q, mask_w);
                if (!pp_hit[3]) begin
                    pp_hit    = scan_next(idx_q, !dir_up_q, mask_w);
                    pp_eff_up = !dir_up_q;
                end
                if (pp_hit[3]) begin
                    adv_idx   = pp_hit[2:0];
                    pp_beyond = scan_next(pp_hit[2:0], pp_eff_up, mask_w);
                    if (pp_beyond[3]) begin
                        adv_dir_up = pp_eff_up;
                    end else begin
                        adv_dir_up = !pp_eff_up;
                        adv_wrap   = !pp_eff_up;
                    end
                end
            end
            default: begin
                // Hold: the index never moves and no sweep ever completes.
            end
        endcase
    end

    // Next-state and next-register logic; stop has priority over start.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        mode_d    = mode_q;
        oneshot_d = oneshot_q;
        dwell_d   = dwell_q;
        wrap_d    = 1'b0;
        if (stop) begin
            state_d  = S_IDLE;
            idx_d    = 3'd0;
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end else if (start && !all_masked) begin
            state_d   = S_RUN;
            mode_d    = mode;
            oneshot_d = oneshot;
            dwell_d   = dwell;
            idx_d     = first_idx;
            dir_up_d  = 1'b1;
            cnt_d     = dwell;
        end else if (state_q == S_RUN && en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else if (all_masked) begin
                state_d  = S_IDLE;
                idx_d    = 3'd0;
                dir_up_d = 1'b1;
            end else if (adv_wrap && oneshot_q) begin
                // The completing index is never shown; drop straight to IDLE.
                state_d  = S_IDLE;
                idx_d    = 3'd0;
                dir_up_d = 1'b1;
                wrap_d   = 1'b1;
            end else begin
                idx_d    = adv_idx;
                dir_up_d = adv_dir_up;
                wrap_d   = adv_wrap;
                cnt_d    = dwell_q;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            mode_q    <= 2'b00;
            oneshot_q <= 1'b0;
            dwell_q   <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            mode_q    <= mode_d;
            oneshot_q <= oneshot_d;
            dwell_q   <= dwell_d;
            wrap_q    <= wrap_d;
        end
    end

    assign a         = idx_q[2];
    assign b         = idx_q[1];
    assign c         = idx_q[0];
    assign sel_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl (default build, no skip mask).
// Driver tasks push the expected {sel_valid, wrap, idx} for every cycle in
// which the DUT presents output; a monitor pops and compares on each negedge.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       en;
    logic [1:0] mode;
    logic       oneshot;
    logic [7:0] dwell;
    logic       a, b, c;
    logic       sel_valid;
    logic       wrap;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .mode      (mode),
        .oneshot   (oneshot),
        .dwell     (dwell),
        .a         (a),
        .b         (b),
        .c         (c),
        .sel_valid (sel_valid),
        .wrap      (wrap),
        .busy      (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each presented output against the scoreboard head.
    always @(negedge clk) begin
        logic [4:0] got;
        logic [4:0] exp_v;
        if (rst_n && (sel_valid || wrap)) begin
            got = {sel_valid, wrap, a, b, c};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scan_out unexpected output sel=%0b wrap=%0b idx=%0d, none expected",
                         got[4], got[3], got[2:0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL scan_out got sel=%0b wrap=%0b idx=%0d, expected sel=%0b wrap=%0b idx=%0d",
                             got[4], got[3], got[2:0], exp_v[4], exp_v[3], exp_v[2:0]);
                end
            end
            checks++;
            if (busy !== sel_valid) begin
                errors++;
                $display("FAIL busy_eq got busy=%0b, expected %0b", busy, sel_valid);
            end
        end
    end

    // Driver tasks
    task automatic push_run(input logic [2:0] v, input int n);
        repeat (n) exp_q.push_back({1'b1, 1'b0, v});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic os, input logic [7:0] dw);
        mode    = m;
        oneshot = os;
        dwell   = dw;
        start   = 1'b1;
        wait_cyc(1);
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
    endtask

    task automatic check_idle(input string name);
        logic [5:0] got;
        got = {sel_valid, wrap, busy, a, b, c};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL %s got {sel,wrap,busy,abc}=%b, expected 000000", name, got);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending outputs, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Stimulus
    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        en      = 1'b1;
        mode    = 2'b00;
        oneshot = 1'b0;
        dwell   = 8'd0;
        #12;
        check_idle("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cyc(3);
        check_idle("idle_after_reset");

        // Free-running up, dwell=2: each index for 3 cycles, wrap on 7->0.
        for (int i = 0; i < 8; i++) push_run(3'(i), 3);
        exp_q.push_back(5'b11_000);
        push_run(3'd0, 2);
        pulse_start(2'b00, 1'b0, 8'd2);
        wait_cyc(26);
        pulse_stop();
        check_idle("up_free_stop");

        // Ping-pong one-shot, dwell=0: 0..7,6..1 then wrap into IDLE.
        for (int i = 0; i < 8; i++) push_run(3'(i), 1);
        for (int i = 6; i >= 1; i--) push_run(3'(i), 1);
        exp_q.push_back(5'b01_000);
        pulse_start(2'b10, 1'b1, 8'd0);
        wait_cyc(16);
        check_idle("pingpong_oneshot_end");

        // Down with en toggling, dwell=1: each index spans 4 cycles.
        push_run(3'd7, 4);
        push_run(3'd6, 4);
        push_run(3'd5, 4);
        push_run(3'd4, 4);
        pulse_start(2'b01, 1'b0, 8'd1);
        for (int k = 2; k <= 16; k++) begin
            en = (k % 2 == 1);
            wait_cyc(1);
        end
        en = 1'b1;
        pulse_stop();
        check_idle("down_en_gating");

        // Down one-shot, dwell=0: 7..0 then wrap on the 0->7 step into IDLE.
        for (int i = 7; i >= 0; i--) push_run(3'(i), 1);
        exp_q.push_back(5'b01_000);
        pulse_start(2'b01, 1'b1, 8'd0);
        wait_cyc(10);
        check_idle("down_oneshot_end");

        // Hold mode, one-shot: index stays 0 and never terminates on its own.
        push_run(3'd0, 10);
        pulse_start(2'b11, 1'b1, 8'd0);
        wait_cyc(9);
        pulse_stop();
        check_idle("hold_stop");

        // Restart at idx=5 (no wrap), then start+stop together.
        for (int i = 0; i < 6; i++) push_run(3'(i), 1);
        push_run(3'd0, 1);
        push_run(3'd1, 1);
        push_run(3'd2, 1);
        pulse_start(2'b00, 1'b0, 8'd0);
        wait_cyc(5);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(2);
        start = 1'b1;
        stop  = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        wait_cyc(1);
        check_idle("start_stop_collision");

        // Asynchronous reset mid-sweep.
        push_run(3'd0, 1);
        push_run(3'd1, 1);
        pulse_start(2'b00, 1'b0, 8'd0);
        wait_cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(4);
        check_idle("idle_after_midrun_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Registered scan sequencer that generates the 3-bit select {a,b,c} driving the downstream decoder3to8 stage. It steps an index through the 8 decoder outputs using up, down or ping-pong order, with a programmable dwell per index. It supports free-running and one-shot sweeps, and flags the end of each sweep. It sits directly upstream of the decoder in scanned-output designs such as LED and keypad scanning, and channel multiplexing.

## Interface
- DWELL_W, 8, width of dwell count; hold time per index is dwell+1 enabled cycles
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  pulse; begins a sweep, or restarts one already running; samples mode, oneshot and dwell
- stop  input  1  pulse; aborts a sweep and returns the block to IDLE
- en  input  1  clock enable for dwell counting and advancing; when low, all state holds
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
- oneshot  input  1  1 = perform a single sweep, then return to IDLE
- dwell  input  DWELL_W  cycles per index minus one
- a, b, c  output  1 each  registered index; a = MSB, c = LSB; connects straight to decoder a,b,c
- sel_valid  output  1  high while in RUN; downstream gates decoder outputs with it
- wrap  output  1  one-cycle pulse on sweep completion
- busy  output  1  equals sel_valid; reserved for status registers

## Operation
- States:
  - IDLE: sel_valid=0, idx=0
  - RUN: sel_valid=1
- IDLE to RUN: on start with stop=0.
  - Load mode, oneshot and dwell into shadow registers.
  - Set idx to the first index: 0 for up and ping-pong, 7 for down.
  - Set dir=up and cnt=dwell.
- RUN, en=1, cnt≠0: cnt decrements.
- RUN, en=1, cnt=0: idx advances and cnt reloads from shadow dwell. Advance rules by mode:
  - Up: idx+1 mod 8. The sweep completes on the 7→0 step.
  - Down: idx−1 mod 8. The sweep completes on the 0→7 step.
  - Ping-pong: sequence 0,1,…,7,6,…,1,0,1,…
    - Endpoints are never repeated.
    - dir flips on reaching 7 and on reaching 0.
    - The sweep completes on the 1→0 step.
  - Hold: idx is never changed, wrap never fires, and oneshot never terminates.
- Sweep completion:
  - With oneshot=0: wrap pulses in the cycle the new idx appears.
  - With oneshot=1: wrap pulses, the state goes to IDLE, and idx=0. The completing idx value is never output.
- start in RUN: restarts exactly as from IDLE. No wrap is generated.
- stop: goes to IDLE next cycle regardless of en. stop overrides start when both are asserted together.
- Mode, oneshot and dwell changes during RUN are ignored until the next start.
- Reset: state=IDLE, idx=0, cnt=0, dir=up. a, b, c, sel_valid, wrap and busy all read 0.

## Timing
- All outputs are registered with no combinational input-to-output path.
- start sampled at edge N: sel_valid=1 and the first idx are visible after edge N. Latency is 1 cycle.
- Each index is held for (dwell+1) cycles with en high. Cycles with en low do not count.
- With dwell=0 and en=1: a new idx every cycle. A full up sweep takes 8 cycles, a full ping-pong sweep takes 14 cycles.
- wrap is high for exactly 1 cycle, aligned with the idx update. In oneshot mode it is aligned with sel_valid falling.
- stop at edge N: sel_valid=0 and idx=0 after edge N.
- Asserting rst_n low mid-sweep clears all outputs immediately, without waiting for clk.

## Configuration
- SCAN_MASK_EN: when defined, adds input skip_mask [7:0]. A 1 means the index is skipped.
  - The advance searches in the current direction for the next unmasked index, checking at most 8 positions.
  - The first index chosen on start is the first unmasked index from the start point.
  - Wrap is detected when the search crosses the boundary for the mode (7→0, 0→7, or the ping-pong low turnaround).
  - In ping-pong mode, dir flips when no unmasked index remains ahead.
  - If all 8 bits are masked, start is ignored and the block stays in IDLE. skip_mask becoming all-ones in RUN forces IDLE on the next advance.
  - The mask is sampled live, not shadowed.
- Without the macro: the port is absent and every index is visited.

## Test plan
- Reset check: rst_n=0 mid-run → a,b,c=000, sel_valid=0, wrap=0 asynchronously. After release, the block stays IDLE until start.
- Free-running up: mode=00, dwell=2, en=1, start → idx 0..7, each held 3 cycles, wrapping to 0. wrap pulses once every 24 cycles.
- Ping-pong one-shot: mode=10, dwell=0, oneshot=1 → 0,1,…,7,6,…,1 over 14 cycles, then wrap=1, sel_valid=0, idx=0.
- en gating: mode=01, dwell=1, en toggling 1/0 → down sequence 7,6,… with each index held for 2 en-high cycles. State freezes while en=0.
- Control collision: start and stop asserted together in RUN → IDLE. start alone in RUN at idx=5 → idx=0 next cycle, no wrap.
- With SCAN_MASK_EN: skip_mask=8'b1010_1010, mode=00, dwell=0 → 0,2,4,6,0, with wrap on 6→0. With skip_mask=8'hFF, start is ignored.
